// File: rtl/aes_sbox_pkg.sv
// aes_sbox_pkg: shared definitions for the AES S-box datapath.
//   - mode_e        : per-transaction operating mode encodings
//   - GF_INV_TABLE  : 256-entry GF(2^8) multiplicative inverse table, inv(0)=0
//   - gf_inv        : table lookup of the GF(2^8) inverse
//   - affine        : AES forward affine transform, constant 0x63
//   - invaffine     : AES inverse affine transform, constant 0x05
package aes_sbox_pkg;

  typedef enum logic [1:0] {
    MODE_SUB    = 2'b00,
    MODE_INVSUB = 2'b01,
    MODE_GFINV  = 2'b10,
    MODE_BYPASS = 2'b11
  } mode_e;

  localparam logic [7:0] AFFINE_C    = 8'h63;
  localparam logic [7:0] INVAFFINE_C = 8'h05;
  // Reduction of x^8 when shifting out of bit 7: x^8 = x^4+x^3+x+1.
  localparam logic [7:0] GF_POLY_LO  = 8'h1B;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? GF_POLY_LO : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^-1 in GF(2^8); 254 = 2+4+...+128, and 0 maps to 0 naturally.
  function automatic logic [7:0] gf_pow254(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [255:0][7:0] build_inv_table();
    logic [255:0][7:0] t;
    for (int i = 0; i < 256; i++) begin
      t[i] = gf_pow254(8'(i));
    end
    return t;
  endfunction

  // Elaborated into a constant, so lookups synthesise as a plain ROM.
  localparam logic [255:0][7:0] GF_INV_TABLE = build_inv_table();

  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    return GF_INV_TABLE[x];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ AFFINE_C;
  endfunction

  function automatic logic [7:0] invaffine(input logic [7:0] b);
    return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ INVAFFINE_C;
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// sbox_lane: combinational single-byte S-box slice.
//   pre_mode/raw  -> pre  : pre-transform (invaffine for inverse S-box, else identity)
//   post_mode/pre_in -> post : GF inverse lookup plus post-transform
// The two halves are separate so the parent can put a register between them.
module sbox_lane
  import aes_sbox_pkg::*;
(
  input  logic [1:0] pre_mode,
  input  logic [7:0] raw,
  output logic [7:0] pre,
  input  logic [1:0] post_mode,
  input  logic [7:0] pre_in,
  output logic [7:0] post
);

  // Pre-transform ahead of the inverse lookup.
  always_comb begin
    pre = raw;
    if (pre_mode == MODE_INVSUB) begin
      pre = invaffine(raw);
    end else begin
      pre = raw;
    end
  end

  // Inverse lookup and post-transform.
  always_comb begin
    post = pre_in;
    case (post_mode)
      MODE_SUB:    post = affine(gf_inv(pre_in));
      MODE_INVSUB: post = gf_inv(pre_in);
      MODE_GFINV:  post = gf_inv(pre_in);
      default:     post = pre_in;
    endcase
  end

endmodule

// File: rtl/sbox_lut_pipe.sv
// sbox_lut_pipe: LANES-wide pipelined AES S-box with valid/ready handshake.
//   clk, rst (sync, active-high), flush (sync pipeline clear)
//   in_valid/in_ready, in_mode, in_data[8*LANES], in_tag[TAG_W] : input transaction
//   out_valid/out_ready, out_data, out_tag                      : output transaction
//   busy : any stage holds a valid transaction
// Stage 1 holds the pre-transform (or the full result when PIPE_STAGES=1),
// stage 2 the post-transformed result, stage 3 an extra output register.
module sbox_lut_pipe
  import aes_sbox_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [8*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int N  = PIPE_STAGES;
  localparam int DW = 8 * LANES;

  generate
    if (LANES < 1 || LANES > 16 || PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_params
      $error("sbox_lut_pipe: illegal parameters LANES=%0d PIPE_STAGES=%0d", LANES, PIPE_STAGES);
    end
  endgenerate

  logic [N-1:0]             valid_r;
  logic [N-1:0][DW-1:0]     data_r;
  logic [N-1:0][TAG_W-1:0]  tag_r;
  logic [1:0]               mode1_r;

  logic [N-1:0]             go_s;
  logic [N-1:0]             up_valid_s;
  logic [N-1:0][DW-1:0]     up_data_s;
  logic [N-1:0][TAG_W-1:0]  up_tag_s;
  logic [DW-1:0]            pre_s;
  logic [DW-1:0]            post_s;
  logic [DW-1:0]            post_in_s;
  logic [1:0]               post_mode_s;

  // With one stage the lane is used fully combinationally from the inputs.
  assign post_in_s   = (N == 1) ? pre_s   : data_r[0];
  assign post_mode_s = (N == 1) ? in_mode : mode1_r;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      sbox_lane u_lane (
        .pre_mode  (in_mode),
        .raw       (in_data[8*i +: 8]),
        .pre       (pre_s[8*i +: 8]),
        .post_mode (post_mode_s),
        .pre_in    (post_in_s[8*i +: 8]),
        .post      (post_s[8*i +: 8])
      );
    end
  endgenerate

  // Stage k may load when it, or every stage after it, can move on; this is
  // the unrolled form of go_k = !valid_k || go_{k+1}, go_last+1 = out_ready.
  always_comb begin
    logic full_s;
    go_s   = '0;
    full_s = 1'b1;
    for (int k = 0; k < N; k++) begin
      full_s = 1'b1;
      for (int j = k; j < N; j++) begin
        full_s = full_s & valid_r[j];
      end
      go_s[k] = out_ready | ~full_s;
    end
  end

  // What each stage would load: the input side for stage 1, the previous stage otherwise.
  always_comb begin
    up_valid_s    = '0;
    up_data_s     = '0;
    up_tag_s      = '0;
    up_valid_s[0] = in_valid;
    up_data_s[0]  = (N == 1) ? post_s : pre_s;
    up_tag_s[0]   = in_tag;
    for (int k = 1; k < N; k++) begin
      up_valid_s[k] = valid_r[k-1];
      up_tag_s[k]   = tag_r[k-1];
      if (k == 1) begin
        up_data_s[k] = post_s;
      end else begin
        up_data_s[k] = data_r[k-1];
      end
    end
  end

  // Pipeline registers: reset beats flush, flush beats any load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      data_r  <= '0;
      tag_r   <= '0;
      mode1_r <= 2'b00;
    end else if (flush) begin
      valid_r <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (go_s[k]) begin
          valid_r[k] <= up_valid_s[k];
          if (up_valid_s[k]) begin
            data_r[k] <= up_data_s[k];
            tag_r[k]  <= up_tag_s[k];
          end
        end
      end
      if (go_s[0] && in_valid) begin
        mode1_r <= in_mode;
      end
    end
  end

  assign in_ready  = go_s[0];
  assign out_valid = valid_r[N-1];
  assign out_data  = data_r[N-1];
  assign out_tag   = tag_r[N-1];
  assign busy      = |valid_r;

endmodule

// File: tb/tb_sbox_lut_pipe.sv
module tb_sbox_lut_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, drv_valid, out_ready, sweep_en;
  logic [1:0]  in_mode;
  logic [31:0] in_data;
  logic [3:0]  in_tag;

  logic        rdy1, rdy2, rdy3, ov1, ov2, ov3, busy1, busy2, busy3;
  logic [31:0] od1, od2, od3;
  logic [3:0]  ot1, ot2, ot3;
  logic        all_ready, iv_sweep, iv2;

  int checks = 0;
  int errors = 0;

  int inv_t[256], sbox_t[256], isbox_t[256];
  logic [35:0] q1[$], q2[$], q3[$];

  always #5 clk = ~clk;

  assign all_ready = rdy1 & rdy2 & rdy3;
  assign iv_sweep  = sweep_en & drv_valid & all_ready;
  assign iv2       = sweep_en ? iv_sweep : drv_valid;

  sbox_lut_pipe #(.LANES(4), .PIPE_STAGES(1), .TAG_W(4)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv_sweep), .in_ready(rdy1),
    .in_mode(in_mode), .in_data(in_data), .in_tag(in_tag), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .out_tag(ot1), .busy(busy1));

  sbox_lut_pipe #(.LANES(4), .PIPE_STAGES(2), .TAG_W(4)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv2), .in_ready(rdy2),
    .in_mode(in_mode), .in_data(in_data), .in_tag(in_tag), .out_valid(ov2),
    .out_ready(out_ready), .out_data(od2), .out_tag(ot2), .busy(busy2));

  sbox_lut_pipe #(.LANES(4), .PIPE_STAGES(3), .TAG_W(4)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv_sweep), .in_ready(rdy3),
    .in_mode(in_mode), .in_data(in_data), .in_tag(in_tag), .out_valid(ov3),
    .out_ready(out_ready), .out_data(od3), .out_tag(ot3), .busy(busy3));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: GF(2^8) arithmetic mod 0x11B with plain integers.
  function automatic int gmul(int a, int b);
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if ((b & 1) != 0) p = p ^ a;
      b = b >> 1;
      a = a << 1;
      if ((a & 256) != 0) a = a ^ 283;
    end
    return p;
  endfunction

  function automatic int bitof(int v, int i);
    return (v >> (i % 8)) & 1;
  endfunction

  function automatic int exp_lane(int mode, int x);
    case (mode)
      0:       return sbox_t[x];
      1:       return isbox_t[x];
      2:       return inv_t[x];
      default: return x;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(int mode, logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(exp_lane(mode, int'(w[8*i +: 8])));
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitors for the sweep: every handshake must match the next expected entry.
  always @(negedge clk) begin
    if (sweep_en && !rst) begin
      if (ov1 && out_ready) begin
        if (q1.size() == 0) check("p1_extra", 64'd1, 64'd0);
        else check("p1_out", {28'd0, ot1, od1}, {28'd0, q1.pop_front()});
      end
      if (ov2 && out_ready) begin
        if (q2.size() == 0) check("p2_extra", 64'd1, 64'd0);
        else check("p2_out", {28'd0, ot2, od2}, {28'd0, q2.pop_front()});
      end
      if (ov3 && out_ready) begin
        if (q3.size() == 0) check("p3_extra", 64'd1, 64'd0);
        else check("p3_out", {28'd0, ot3, od3}, {28'd0, q3.pop_front()});
      end
    end
  end

  logic [31:0] bp_d[3];
  int          bp_m[3];
  logic [31:0] e;
  logic [31:0] d;
  int          m, cnt, waited;
  logic [3:0]  tg;

  initial begin
    // Build reference tables: inverse by exhaustive search, S-box from the affine bit equation.
    inv_t[0] = 0;
    for (int x = 1; x < 256; x++)
      for (int y = 1; y < 256; y++)
        if (gmul(x, y) == 1) inv_t[x] = y;
    for (int x = 0; x < 256; x++) begin
      int y, s;
      y = inv_t[x];
      s = 0;
      for (int i = 0; i < 8; i++)
        s = s | ((bitof(y, i) ^ bitof(y, i + 4) ^ bitof(y, i + 5) ^ bitof(y, i + 6)
                  ^ bitof(y, i + 7) ^ bitof(32'h63, i)) << i);
      sbox_t[x] = s;
    end
    for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = x;

    rst = 1'b1; flush = 1'b0; drv_valid = 1'b0; out_ready = 1'b1; sweep_en = 1'b0;
    in_mode = 2'b00; in_data = 32'h0; in_tag = 4'h0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_out_valid", {63'd0, ov2}, 64'd0);
    check("rst_out_data", {32'd0, od2}, 64'd0);
    check("rst_out_tag", {60'd0, ot2}, 64'd0);
    check("rst_busy", {63'd0, busy2}, 64'd0);
    check("rst_in_ready", {63'd0, rdy2}, 64'd1);

    // Single forward S-box transfer, latency 2.
    drv_valid = 1'b1; in_mode = 2'b00; in_data = 32'h53FF0100; in_tag = 4'hA;
    step();
    drv_valid = 1'b0;
    check("t1_lat1_valid", {63'd0, ov2}, 64'd0);
    step();
    check("t1_valid", {63'd0, ov2}, 64'd1);
    check("t1_data", {32'd0, od2}, {32'd0, 32'hED167C63});
    check("t1_tag", {60'd0, ot2}, 64'hA);
    check("t1_busy", {63'd0, busy2}, 64'd1);
    step();
    check("t1_valid_after", {63'd0, ov2}, 64'd0);
    check("t1_busy_after", {63'd0, busy2}, 64'd0);

    // Back-to-back mode change.
    drv_valid = 1'b1; in_mode = 2'b01; in_data = 32'hED167C63; in_tag = 4'h1;
    step();
    in_mode = 2'b10; in_data = 32'h53020100; in_tag = 4'h2;
    step();
    drv_valid = 1'b0;
    check("t2_a_valid", {63'd0, ov2}, 64'd1);
    check("t2_a_data", {32'd0, od2}, {32'd0, 32'h53FF0100});
    check("t2_a_tag", {60'd0, ot2}, 64'h1);
    step();
    check("t2_b_valid", {63'd0, ov2}, 64'd1);
    check("t2_b_data", {32'd0, od2}, {32'd0, 32'hCA8D0100});
    check("t2_b_tag", {60'd0, ot2}, 64'h2);
    step();
    check("t2_empty", {63'd0, ov2}, 64'd0);

    // Backpressure: two accepted, third blocked, then ordered drain.
    for (int i = 0; i < 3; i++) begin
      bp_d[i] = $urandom;
      bp_m[i] = int'($urandom_range(3, 0));
    end
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      drv_valid = 1'b1; in_mode = 2'(bp_m[i]); in_data = bp_d[i]; in_tag = 4'(3 + i);
      #1;
      check("bp_ready_open", {63'd0, rdy2}, 64'd1);
      step();
    end
    in_mode = 2'(bp_m[2]); in_data = bp_d[2]; in_tag = 4'h5;
    e = exp_word(bp_m[0], bp_d[0]);
    for (int c = 0; c < 3; c++) begin
      check("bp_ready_full", {63'd0, rdy2}, 64'd0);
      check("bp_hold_valid", {63'd0, ov2}, 64'd1);
      check("bp_hold_data", {32'd0, od2}, {32'd0, e});
      check("bp_hold_tag", {60'd0, ot2}, 64'h3);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_release", {63'd0, rdy2}, 64'd1);
    step();
    drv_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      check("bp_drain_valid", {63'd0, ov2}, 64'd1);
      check("bp_drain_data", {32'd0, od2}, {32'd0, exp_word(bp_m[i], bp_d[i])});
      check("bp_drain_tag", {60'd0, ot2}, {60'd0, 4'(3 + i)});
      step();
    end
    check("bp_drained", {63'd0, ov2}, 64'd0);

    // Flush with two in flight and an input offered in the flush cycle.
    out_ready = 1'b0;
    drv_valid = 1'b1; in_mode = 2'b00; in_data = 32'h11223344; in_tag = 4'h6;
    step();
    in_data = 32'h55667788; in_tag = 4'h7;
    step();
    check("fl_busy_before", {63'd0, busy2}, 64'd1);
    flush = 1'b1; out_ready = 1'b1; in_data = 32'h99AABBCC; in_tag = 4'h8;
    step();
    flush = 1'b0; drv_valid = 1'b0;
    check("fl_out_valid", {63'd0, ov2}, 64'd0);
    check("fl_busy", {63'd0, busy2}, 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("fl_no_ghost", {63'd0, ov2}, 64'd0);
    end

    // Exhaustive sweep across PIPE_STAGES 1/2/3 with random backpressure,
    // plus inverse-S-box round trip of every forward S-box output.
    sweep_en = 1'b1;
    cnt = 0;
    for (int x = 0; x < 256; x++) begin
      for (int k = 0; k < 5; k++) begin
        m = (k == 4) ? 1 : k;
        for (int i = 0; i < 4; i++) begin
          if (k == 4) begin
            d[8*i +: 8] = 8'(sbox_t[(x + i) % 256]);
            e[8*i +: 8] = 8'((x + i) % 256);
          end else begin
            d[8*i +: 8] = 8'((x + i) % 256);
            e[8*i +: 8] = 8'(exp_lane(m, (x + i) % 256));
          end
        end
        tg = 4'(cnt);
        cnt++;
        drv_valid = 1'b1; in_mode = 2'(m); in_data = d; in_tag = tg;
        waited = 0;
        forever begin
          out_ready = ($urandom_range(3, 0) != 0);
          #1;
          if (all_ready) begin
            q1.push_back({tg, e}); q2.push_back({tg, e}); q3.push_back({tg, e});
            step();
            break;
          end
          step();
          waited++;
          if (waited > 100) begin
            check("sw_accept_timeout", 64'd1, 64'd0);
            break;
          end
        end
      end
    end
    drv_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    check("sw_q1_empty", 64'(q1.size()), 64'd0);
    check("sw_q2_empty", 64'(q2.size()), 64'd0);
    check("sw_q3_empty", 64'(q3.size()), 64'd0);
    sweep_en = 1'b0;

    // Reset mid-stream while output is valid.
    drv_valid = 1'b1; in_mode = 2'b11; in_data = $urandom; in_tag = 4'h9;
    step();
    step();
    check("mr_pre_valid", {63'd0, ov2}, 64'd1);
    rst = 1'b1; drv_valid = 1'b0;
    step();
    rst = 1'b0;
    check("mr_out_valid", {63'd0, ov2}, 64'd0);
    check("mr_out_data", {32'd0, od2}, 64'd0);
    check("mr_in_ready", {63'd0, rdy2}, 64'd1);
    check("mr_busy", {63'd0, busy2}, 64'd0);
    step();
    check("mr_stays_empty", {63'd0, ov2}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
